// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : ctrl_pkg
// Brief   : Opcodes, ALU codes, state encoding and decode helpers shared by
//           the hardwired control sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  // Instruction opcodes (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_AND = 5'b00011;
  localparam logic [4:0] ALU_OR  = 5'b00100;

  // Sequencer states; the encoding doubles as the debug step index
  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  typedef enum logic [2:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_RTYPE, CLS_IMM, CLS_HALT, CLS_ILL
  } op_class_t;

  // One bit per datapath control line (PC_enable is not driven by any step)
  typedef struct packed {
    logic pc_sel;
    logic mdr_sel;
    logic zlo_sel;
    logic c_sel;
    logic pc_inc;
    logic ir_en;
    logic y_en;
    logic z_en;
    logic mar_en;
    logic mdr_en;
    logic r_en;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic rout;
    logic baout;
    logic illegal;
    logic halted;
  } ctrl_t;

  function automatic op_class_t decode_class(input logic [4:0] op);
    case (op)
      OP_LD:                        return CLS_LD;
      OP_LDI:                       return CLS_LDI;
      OP_ST:                        return CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:     return CLS_IMM;
      OP_HALT:                      return CLS_HALT;
      default:                      return CLS_ILL;
    endcase
  endfunction

  // Loads and stores use ADD for the effective-address computation
  function automatic logic [4:0] decode_alu(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module : mem_wait_timer
// Brief  : Counts memory wait cycles for the sequencer and flags a timeout
//          when the count reaches MEM_TIMEOUT (0 disables the timeout).
// Rev    : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
  parameter int TMR_W       = 8,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_active,
  input  logic             i_ready,
  output logic [TMR_W-1:0] o_count,
  output logic             o_timeout
);

  localparam logic [TMR_W-1:0] C_LIMIT = TMR_W'(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] C_MAX   = '1;

  logic [TMR_W-1:0] r_count;

  // Clear on wait-state entry, count stalled cycles, saturate so zero means "first cycle"
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= '0;
    end else if (i_active && !i_ready && (r_count != C_MAX)) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  assign o_count   = r_count;
  // A ready memory on the limit cycle takes priority over the timeout
  assign o_timeout = (MEM_TIMEOUT != 0) && i_active && !i_ready && (r_count == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ctrl_sequencer
// Brief  : Hardwired control unit: fetch T0-T2, decode, per-class execute
//          T3-T7 with memory wait states, timeout, halt and illegal-op detect.
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 5,
  parameter int ALU_OP_W    = 5,
  parameter int MEM_TIMEOUT = 0,
  parameter int TMR_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [OPCODE_W-1:0] ir_opcode,
  output logic                PC_select,
  output logic                MDR_select,
  output logic                Z_LO_select,
  output logic                c_select,
  output logic                PC_enable,
  output logic                PC_increment_enable,
  output logic                IR_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                MAR_enable,
  output logic                MDR_enable,
  output logic                r_enable,
  output logic                read,
  output logic                write,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rout,
  output logic                BAout,
  output logic [ALU_OP_W-1:0] alu_instruction,
  output logic [3:0]          step,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_error
);

  logic [3:0]          r_state;
  logic [3:0]          w_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [4:0]          w_op5;
  op_class_t           w_class;
  logic                w_mem_cls;
  logic                w_wait;
  logic                w_next_wait;
  logic                w_start;
  logic                w_timeout;
  logic [TMR_W-1:0]    w_count;
  ctrl_t               w_ctrl;
  logic [ALU_OP_W-1:0] w_alu;

  // Opcodes with any bit set above the 5-bit field are undefined
  assign w_op5     = r_opcode[4:0];
  assign w_class   = (r_opcode == OPCODE_W'(w_op5)) ? decode_class(w_op5) : CLS_ILL;
  assign w_mem_cls = (w_class == CLS_LD) || (w_class == CLS_ST);

  // Wait states: fetch read, LD data read, ST data write
  assign w_wait      = (r_state == S_T1) || ((r_state == S_T6) && (w_class == CLS_LD)) ||
                       ((r_state == S_T7) && (w_class == CLS_ST));
  assign w_next_wait = (w_next == S_T1) || ((w_next == S_T6) && (w_class == CLS_LD)) ||
                       ((w_next == S_T7) && (w_class == CLS_ST));
  assign w_start     = w_next_wait && (w_next != r_state);

  mem_wait_timer #(
    .TMR_W       (TMR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .i_start   (w_start),
    .i_active  (w_wait),
    .i_ready   (mem_ready),
    .o_count   (w_count),
    .o_timeout (w_timeout)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode is captured as IR is loaded, at the T2->T3 edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opcode <= '0;
    end else if (r_state == S_T2) begin
      r_opcode <= ir_opcode;
    end
  end

  // Next-state sequencing
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0:  if (run) w_next = S_T1;
      S_T1: begin
        if (mem_ready)      w_next = S_T2;
        else if (w_timeout) w_next = S_T0;
      end
      S_T2:  w_next = S_T3;
      S_T3: begin
        case (w_class)
          CLS_HALT: w_next = S_HALT;
          CLS_ILL:  w_next = S_T0;
          default:  w_next = S_T4;
        endcase
      end
      S_T4:  w_next = S_T5;
      S_T5:  w_next = w_mem_cls ? S_T6 : S_T0;
      S_T6: begin
        if ((w_class == CLS_ST) || mem_ready) w_next = S_T7;
        else if (w_timeout)                   w_next = S_T0;
      end
      S_T7: begin
        if ((w_class == CLS_LD) || mem_ready || w_timeout) w_next = S_T0;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  // Moore control decode from state and latched opcode (T0 also gated by run)
  always_comb begin
    w_ctrl = '0;
    w_alu  = '0;
    case (r_state)
      S_T0: begin
        w_ctrl.pc_sel = run;
        w_ctrl.mar_en = run;
      end
      S_T1: begin
        w_ctrl.read   = 1'b1;
        w_ctrl.mdr_en = 1'b1;
        w_ctrl.pc_inc = (w_count == '0);
      end
      S_T2: begin
        w_ctrl.mdr_sel = 1'b1;
        w_ctrl.ir_en   = 1'b1;
      end
      S_T3: begin
        case (w_class)
          CLS_LD, CLS_LDI, CLS_ST: begin
            w_ctrl.grb   = 1'b1;
            w_ctrl.baout = 1'b1;
            w_ctrl.y_en  = 1'b1;
          end
          CLS_RTYPE, CLS_IMM: begin
            w_ctrl.grb  = 1'b1;
            w_ctrl.rout = 1'b1;
            w_ctrl.y_en = 1'b1;
          end
          CLS_ILL: w_ctrl.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        w_ctrl.z_en = 1'b1;
        w_alu       = ALU_OP_W'(decode_alu(w_op5));
        if (w_class == CLS_RTYPE) begin
          w_ctrl.grc  = 1'b1;
          w_ctrl.rout = 1'b1;
        end else begin
          w_ctrl.c_sel = 1'b1;
        end
      end
      S_T5: begin
        w_ctrl.zlo_sel = 1'b1;
        if (w_mem_cls) begin
          w_ctrl.mar_en = 1'b1;
        end else begin
          w_ctrl.gra  = 1'b1;
          w_ctrl.r_en = 1'b1;
        end
      end
      S_T6: begin
        w_ctrl.mdr_en = 1'b1;
        if (w_class == CLS_LD) begin
          w_ctrl.read = 1'b1;
        end else begin
          w_ctrl.gra  = 1'b1;
          w_ctrl.rout = 1'b1;
        end
      end
      S_T7: begin
        if (w_class == CLS_LD) begin
          w_ctrl.mdr_sel = 1'b1;
          w_ctrl.gra     = 1'b1;
          w_ctrl.r_en    = 1'b1;
        end else begin
          w_ctrl.write = 1'b1;
        end
      end
      S_HALT: w_ctrl.halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_select           = w_ctrl.pc_sel;
  assign MDR_select          = w_ctrl.mdr_sel;
  assign Z_LO_select         = w_ctrl.zlo_sel;
  assign c_select            = w_ctrl.c_sel;
  assign PC_enable           = 1'b0;
  assign PC_increment_enable = w_ctrl.pc_inc;
  assign IR_enable           = w_ctrl.ir_en;
  assign Y_enable            = w_ctrl.y_en;
  assign Z_enable            = w_ctrl.z_en;
  assign MAR_enable          = w_ctrl.mar_en;
  assign MDR_enable          = w_ctrl.mdr_en;
  assign r_enable            = w_ctrl.r_en;
  assign read                = w_ctrl.read;
  assign write               = w_ctrl.write;
  assign Gra                 = w_ctrl.gra;
  assign Grb                 = w_ctrl.grb;
  assign Grc                 = w_ctrl.grc;
  assign Rout                = w_ctrl.rout;
  assign BAout               = w_ctrl.baout;
  assign alu_instruction     = w_alu;
  assign step                = r_state;
  assign halted              = w_ctrl.halted;
  assign illegal_op          = w_ctrl.illegal;
  assign mem_error           = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ctrl_sequencer
// Brief  : Self-checking bench: builds the expected per-cycle control trace of
//          each instruction from the step tables, drives matching stimulus.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ctrl_sequencer;

  localparam int TMO = 4;

  // Expected-word bit positions (bits 21:0), then alu (26:22), then step (30:27)
  localparam logic [21:0] B_PCSEL  = 22'd1 << 0;
  localparam logic [21:0] B_MDRSEL = 22'd1 << 1;
  localparam logic [21:0] B_ZLO    = 22'd1 << 2;
  localparam logic [21:0] B_CSEL   = 22'd1 << 3;
  localparam logic [21:0] B_PCINC  = 22'd1 << 5;
  localparam logic [21:0] B_IREN   = 22'd1 << 6;
  localparam logic [21:0] B_Y      = 22'd1 << 7;
  localparam logic [21:0] B_Z      = 22'd1 << 8;
  localparam logic [21:0] B_MAR    = 22'd1 << 9;
  localparam logic [21:0] B_MDREN  = 22'd1 << 10;
  localparam logic [21:0] B_REN    = 22'd1 << 11;
  localparam logic [21:0] B_READ   = 22'd1 << 12;
  localparam logic [21:0] B_WRITE  = 22'd1 << 13;
  localparam logic [21:0] B_GRA    = 22'd1 << 14;
  localparam logic [21:0] B_GRB    = 22'd1 << 15;
  localparam logic [21:0] B_GRC    = 22'd1 << 16;
  localparam logic [21:0] B_ROUT   = 22'd1 << 17;
  localparam logic [21:0] B_BA     = 22'd1 << 18;
  localparam logic [21:0] B_HALT   = 22'd1 << 19;
  localparam logic [21:0] B_ILL    = 22'd1 << 20;
  localparam logic [21:0] B_MERR   = 22'd1 << 21;

  localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_R = 3, K_I = 4, K_HALT = 5, K_ILL = 6;

  typedef struct {
    logic        run;
    logic        ready;
    logic [4:0]  op;
    logic [30:0] exp;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic [4:0] ir_opcode = 5'd0;

  logic PC_select, MDR_select, Z_LO_select, c_select, PC_enable, PC_increment_enable;
  logic IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable, read, write;
  logic Gra, Grb, Grc, Rout, BAout, halted, illegal_op, mem_error;
  logic [4:0] alu_instruction;
  logic [3:0] step;
  logic [30:0] w_obs;

  int n_checks = 0;
  int n_err    = 0;
  entry_t q[$];

  ctrl_sequencer #(
    .OPCODE_W    (5),
    .ALU_OP_W    (5),
    .MEM_TIMEOUT (TMO),
    .TMR_W       (8)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir_opcode(ir_opcode),
    .PC_select(PC_select), .MDR_select(MDR_select), .Z_LO_select(Z_LO_select),
    .c_select(c_select), .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .r_enable(r_enable), .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .BAout(BAout),
    .alu_instruction(alu_instruction), .step(step), .halted(halted),
    .illegal_op(illegal_op), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  assign w_obs = {step, alu_instruction, mem_error, illegal_op, halted, BAout, Rout, Grc, Grb,
                  Gra, write, read, r_enable, MDR_enable, MAR_enable, Z_enable, Y_enable,
                  IR_enable, PC_increment_enable, PC_enable, c_select, Z_LO_select,
                  MDR_select, PC_select};

  task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got step=%0d alu=%h ctrl=%h, expected step=%0d alu=%h ctrl=%h",
               tag, got[30:27], got[26:22], got[21:0], exp[30:27], exp[26:22], exp[21:0]);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] rop();
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic int op_cls(input logic [4:0] op);
    case (op)
      5'd0:                   return K_LD;
      5'd1:                   return K_LDI;
      5'd2:                   return K_ST;
      5'd3, 5'd4, 5'd5, 5'd6: return K_R;
      5'd12, 5'd13, 5'd14:    return K_I;
      5'd27:                  return K_HALT;
      default:                return K_ILL;
    endcase
  endfunction

  function automatic logic [4:0] exp_alu(input logic [4:0] op);
    case (op)
      5'd4:        return 5'b00010;
      5'd5, 5'd13: return 5'b00011;
      5'd6, 5'd14: return 5'b00100;
      default:     return 5'b00001;
    endcase
  endfunction

  task automatic add(input logic rn, input logic rd, input logic [4:0] op,
                     input logic [3:0] st, input logic [4:0] alu, input logic [21:0] b);
    entry_t e;
    e.run = rn; e.ready = rd; e.op = op; e.exp = {st, alu, b};
    q.push_back(e);
  endtask

  // w stalled cycles then ready, or (to) TMO+1 unready cycles ending in mem_error
  task automatic add_wait(input logic [3:0] st, input logic [21:0] b, input logic [21:0] first,
                          input int w, input bit to);
    int n;
    n = to ? TMO : w;
    for (int k = 0; k <= n; k++)
      add(rb(), to ? 1'b0 : (k == n), rop(), st, 5'd0,
          b | ((k == 0) ? first : 22'd0) | ((to && k == n) ? B_MERR : 22'd0));
  endtask

  task automatic plan_instr(input logic [4:0] op, input int runlow, input int w1, input bit to1,
                            input int w2, input bit to2);
    int c;
    c = op_cls(op);
    for (int i = 0; i < runlow; i++) add(1'b0, rb(), rop(), 4'd1, 5'd0, 22'd0);
    add(1'b1, rb(), rop(), 4'd1, 5'd0, B_PCSEL | B_MAR);
    add_wait(4'd2, B_READ | B_MDREN, B_PCINC, w1, to1);
    if (to1) return;
    add(rb(), rb(), op, 4'd3, 5'd0, B_MDRSEL | B_IREN);
    if (c == K_HALT) begin
      add(rb(), rb(), rop(), 4'd4, 5'd0, 22'd0);
      for (int i = 0; i < 4; i++) add(1'b1, rb(), rop(), 4'd9, 5'd0, B_HALT);
      return;
    end
    if (c == K_ILL) begin
      add(rb(), rb(), rop(), 4'd4, 5'd0, B_ILL);
      return;
    end
    if (c == K_R || c == K_I) add(rb(), rb(), rop(), 4'd4, 5'd0, B_GRB | B_ROUT | B_Y);
    else                      add(rb(), rb(), rop(), 4'd4, 5'd0, B_GRB | B_BA | B_Y);
    if (c == K_R) add(rb(), rb(), rop(), 4'd5, exp_alu(op), B_GRC | B_ROUT | B_Z);
    else          add(rb(), rb(), rop(), 4'd5, exp_alu(op), B_CSEL | B_Z);
    if (c != K_LD && c != K_ST) begin
      add(rb(), rb(), rop(), 4'd6, 5'd0, B_ZLO | B_GRA | B_REN);
      return;
    end
    add(rb(), rb(), rop(), 4'd6, 5'd0, B_ZLO | B_MAR);
    if (c == K_LD) begin
      add_wait(4'd7, B_READ | B_MDREN, 22'd0, w2, to2);
      if (!to2) add(rb(), rb(), rop(), 4'd8, 5'd0, B_MDRSEL | B_GRA | B_REN);
    end else begin
      add(rb(), rb(), rop(), 4'd7, 5'd0, B_GRA | B_ROUT | B_MDREN);
      add_wait(4'd8, B_WRITE, 22'd0, w2, to2);
    end
  endtask

  // One entry per cycle: drive, settle, compare, advance past the next edge
  task automatic run_queue(input int stop_step);
    entry_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      run = e.run; mem_ready = e.ready; ir_opcode = e.op;
      #1;
      check($sformatf("step%0d", e.exp[30:27]), w_obs, e.exp);
      if (int'(e.exp[30:27]) == stop_step) begin
        reset = 1'b1;
        q.delete();
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1; check("reset", w_obs, 31'd0);
    @(posedge clk); #1; check("reset", w_obs, 31'd0);
    reset = 1'b0;
    add(rb(), rb(), rop(), 4'd0, 5'd0, 22'd0);
  endtask

  initial begin
    logic [4:0] valid [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14};
    logic [4:0] op;
    do_reset();
    plan_instr(5'b00001, 0, 0, 1'b0, 0, 1'b0); run_queue(-1);   // LDI, no waits
    plan_instr(5'b00000, 0, 3, 1'b0, 2, 1'b0); run_queue(-1);   // LD with waits
    plan_instr(5'b00010, 0, 0, 1'b0, 0, 1'b0); run_queue(-1);   // ST
    plan_instr(5'b00000, 1, 0, 1'b1, 0, 1'b0); run_queue(-1);   // fetch timeout
    plan_instr(5'b00000, 0, 4, 1'b0, 4, 1'b0); run_queue(-1);   // ready on the limit cycle
    plan_instr(5'b00000, 0, 0, 1'b0, 0, 1'b1); run_queue(-1);   // LD data timeout
    plan_instr(5'b00010, 0, 1, 1'b0, 0, 1'b1); run_queue(-1);   // ST write timeout
    plan_instr(5'b10101, 0, 0, 1'b0, 0, 1'b0); run_queue(-1);   // illegal
    plan_instr(5'b01100, 2, 1, 1'b0, 0, 1'b0); run_queue(5);    // ADDI aborted in T4
    @(posedge clk); #1;
    check("abort_rst", w_obs, 31'd0);
    reset = 1'b0;
    add(rb(), rb(), rop(), 4'd0, 5'd0, 22'd0);
    plan_instr(5'b11011, 0, 0, 1'b0, 0, 1'b0); run_queue(-1);   // HALT
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 7) op = valid[$urandom_range(0, 9)];
      else                          op = rop();
      plan_instr(op, $urandom_range(0, 2), $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
      run_queue(-1);
      if (op_cls(op) == K_HALT) do_reset();
    end
    run_queue(-1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
